// File: rtl/dmem_lsu.sv
// dmem_lsu - load/store unit between the core memory stage and the data bus.
//
// Decodes RISC-V load/store func3 into byte enables, lane-shifted store data
// and load extension, and runs one bus access at a time through a small FSM.
//
// Build option: define LSU_MISALIGN_SPLIT_EN to split lane-crossing accesses
// into two aligned beats. Without it, such accesses complete with rsp_err=1
// and no bus beat.
//
// Parameters: XLEN (32 or 64) datapath width, AW byte-address width.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      core request handshake (ready only in IDLE)
//   req_we, req_func3        store flag, RISC-V func3 (size + unsigned)
//   req_addr, req_wdata      byte address, right-aligned store data
//   mem_valid/mem_ready      bus beat handshake
//   mem_we, mem_addr         beat direction, lane-aligned beat address
//   mem_be, mem_wdata        byte enables, lane-shifted store data
//   mem_rvalid, mem_rdata    read data for the oldest read beat
//   rsp_valid                one-cycle completion pulse
//   rsp_rdata, rsp_err       extended load data, illegal/misaligned flag
module dmem_lsu #(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [AW-1:0]     req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    localparam int BW = XLEN / 8;
    localparam int OW = $clog2(BW);
`ifdef LSU_MISALIGN_SPLIT_EN
    // Two beats worth of lanes are needed to describe a crossing access.
    localparam int MW = 2 * BW;
    localparam int DW = 2 * XLEN;
`else
    localparam int MW = BW;
    localparam int DW = XLEN;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BUS0 = 3'd1,
        S_RD0  = 3'd2,
`ifdef LSU_MISALIGN_SPLIT_EN
        S_BUS1 = 3'd3,
        S_RD1  = 3'd4,
`endif
        S_RESP = 3'd5
    } state_t;

    // Ones in the low 2^size lanes of an MW-lane mask.
    function automatic logic [MW-1:0] size_mask(input logic [1:0] size);
        logic [MW-1:0] m;
        int            n;
        n = int'(32'd1 << size);
        for (int i = 0; i < MW; i++) begin
            if (i < n) m[i] = 1'b1;
            else       m[i] = 1'b0;
        end
        return m;
    endfunction

    // Keep the low 8*2^size bits, then sign- or zero-extend to XLEN.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d,
                                               input logic [1:0]      size,
                                               input logic            uns);
        logic [XLEN-1:0] r;
        logic            sgn;
        int              nb;
        nb = int'(32'd8 << size);
        if (nb > XLEN) nb = XLEN;
        else           nb = nb;
        sgn = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            if (i == nb - 1) sgn = d[i];
            else             sgn = sgn;
        end
        for (int i = 0; i < XLEN; i++) begin
            if (i < nb)   r[i] = d[i];
            else if (uns) r[i] = 1'b0;
            else          r[i] = sgn;
        end
        return r;
    endfunction

    state_t           state_r;
    logic [1:0]       size_r;
    logic             uns_r;
    logic             we_r;
    logic [OW-1:0]    off_r;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic             split_r;
    logic [BW-1:0]    be_hi_r;
    logic [XLEN-1:0]  wdata_hi_r;
    logic [XLEN-1:0]  buf_lo_r;
    logic [XLEN-1:0]  buf_hi_r;
`endif

    logic [1:0]       size_s;
    logic [OW-1:0]    off_s;
    logic [4:0]       span_s;
    logic             split_s;
    logic             illegal_s;
    logic             err_s;
    logic [MW-1:0]    mask_s;
    logic [DW-1:0]    wvec_s;
    logic [AW-1:0]    base_addr_s;
    logic [DW-1:0]    rvec_s;
    logic [DW-1:0]    rshift_s;
    logic [XLEN-1:0]  load_res_s;

    assign req_ready = (state_r == S_IDLE);

    // Request decode: legality, lane-crossing test, byte mask and store data.
    always_comb begin
        size_s    = req_func3[1:0];
        off_s     = req_addr[OW-1:0];
        span_s    = 5'(off_s) + (5'd1 << size_s);
        split_s   = (span_s > 5'(BW));
        if (req_we && req_func3[2]) begin
            illegal_s = 1'b1;
        end else if ((XLEN == 32) && ((size_s == 2'd3) || (req_func3 == 3'b110))) begin
            illegal_s = 1'b1;
        end else begin
            illegal_s = 1'b0;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        err_s = illegal_s;
`else
        err_s = illegal_s | split_s;
`endif
        mask_s      = size_mask(size_s) << off_s;
        wvec_s      = DW'(req_wdata) << {off_s, 3'b000};
        base_addr_s = {req_addr[AW-1:OW], {OW{1'b0}}};
    end

    // Load data assembly: buf_hi is zero unless the second beat has arrived.
    always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
        if (state_r == S_RD1) rvec_s = {mem_rdata, buf_lo_r};
        else                  rvec_s = {buf_hi_r, mem_rdata};
`else
        rvec_s = mem_rdata;
`endif
        rshift_s   = rvec_s >> {off_r, 3'b000};
        load_res_s = extend(rshift_s[XLEN-1:0], size_r, uns_r);
    end

    // Access FSM with registered bus and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            size_r     <= 2'd0;
            uns_r      <= 1'b0;
            we_r       <= 1'b0;
            off_r      <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_r    <= 1'b0;
            be_hi_r    <= '0;
            wdata_hi_r <= '0;
            buf_lo_r   <= '0;
            buf_hi_r   <= '0;
`endif
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    rsp_valid <= 1'b0;
                    if (req_valid) begin
                        size_r <= size_s;
                        uns_r  <= req_func3[2];
                        we_r   <= req_we;
                        off_r  <= off_s;
`ifdef LSU_MISALIGN_SPLIT_EN
                        split_r    <= split_s;
                        be_hi_r    <= mask_s[2*BW-1:BW];
                        wdata_hi_r <= wvec_s[2*XLEN-1:XLEN];
                        buf_lo_r   <= '0;
                        buf_hi_r   <= '0;
`endif
                        if (err_s) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state_r   <= S_RESP;
                        end else begin
                            mem_valid <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= base_addr_s;
                            mem_be    <= mask_s[BW-1:0];
                            mem_wdata <= wvec_s[XLEN-1:0];
                            state_r   <= S_BUS0;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_BUS0: begin
                    if (mem_ready) begin
                        if (!we_r) begin
                            mem_valid <= 1'b0;
                            state_r   <= S_RD0;
`ifdef LSU_MISALIGN_SPLIT_EN
                        end else if (split_r) begin
                            // Store goes straight to its second beat.
                            mem_addr  <= mem_addr + AW'(BW);
                            mem_be    <= be_hi_r;
                            mem_wdata <= wdata_hi_r;
                            state_r   <= S_BUS1;
`endif
                        end else begin
                            mem_valid <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= '0;
                            state_r   <= S_RESP;
                        end
                    end else begin
                        state_r <= S_BUS0;
                    end
                end
                S_RD0: begin
                    if (mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        buf_lo_r <= mem_rdata;
                        if (split_r) begin
                            mem_valid <= 1'b1;
                            mem_addr  <= mem_addr + AW'(BW);
                            mem_be    <= be_hi_r;
                            mem_wdata <= wdata_hi_r;
                            state_r   <= S_BUS1;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= load_res_s;
                            state_r   <= S_RESP;
                        end
`else
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_res_s;
                        state_r   <= S_RESP;
`endif
                    end else begin
                        state_r <= S_RD0;
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                S_BUS1: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (!we_r) begin
                            state_r <= S_RD1;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= '0;
                            state_r   <= S_RESP;
                        end
                    end else begin
                        state_r <= S_BUS1;
                    end
                end
                S_RD1: begin
                    if (mem_rvalid) begin
                        buf_hi_r  <= mem_rdata;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_res_s;
                        state_r   <= S_RESP;
                    end else begin
                        state_r <= S_RD1;
                    end
                end
`endif
                S_RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    state_r   <= S_IDLE;
                end
                default: begin
                    mem_valid <= 1'b0;
                    rsp_valid <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
